mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM responder with an optional memory-mapped IO transmit FIFO
//   clk_in      in   system clock, rising edge
//   rst_in      in   asynchronous active-low reset
//   mem_a       in   [31:0] CPU byte address, bits 17:0 decoded
//   mem_wr      in   1 = write, 0 = read
//   mem_dout    in   [7:0] CPU write data
//   mem_din     out  [7:0] registered read data, one-cycle latency
//   rdy_out     out  CPU ready; requests are ignored while low
//   io_tx_data  out  [7:0] transmit FIFO head byte, 0x00 when empty
//   io_tx_valid out  transmit FIFO non-empty
//   io_tx_ready in   consumer takes the head byte this cycle
// Define MEM_RESPONDER_IO_EN to map mem_a[17]=1 onto the transmit FIFO
// (write pushes, read returns occupancy); otherwise all addresses are RAM.
module mem_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready
);
  localparam int AW = RAM_ADDR_WIDTH;
  logic [7:0] ram [2**AW];
  logic [AW-1:0] ram_a;
  logic [7:0] din_q;
  logic rdy_q, rdy_d;
  logic io_sel;
  logic [7:0] io_rd;
  logic unused_ok;
  assign ram_a = mem_a[AW-1:0];
  assign unused_ok = ^{mem_a, io_tx_ready};
`ifdef MEM_RESPONDER_IO_EN
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] fifo [TX_FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  assign io_sel = mem_a[17];
  assign push = rdy_q & mem_wr & io_sel;
  assign pop = io_tx_valid & io_tx_ready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  // Ready looks at next occupancy so the push that fills the FIFO is the last one taken.
  assign rdy_d = cnt_d < CW'(TX_FIFO_DEPTH);
  assign io_tx_valid = cnt_q != '0;
  assign io_tx_data = io_tx_valid ? fifo[rp_q] : 8'h00;
  assign io_rd = 8'(cnt_q);
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) fifo[wp_q] <= mem_dout;
  end
`else
  assign io_sel = 1'b0;
  assign rdy_d = 1'b1;
  assign io_tx_valid = 1'b0;
  assign io_tx_data = 8'h00;
  assign io_rd = 8'h00;
`endif
  // RAM contents survive reset, so the array lives outside the reset block.
  always_ff @(posedge clk_in) begin
    if (rdy_q && mem_wr && !io_sel) ram[ram_a] <= mem_dout;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdy_q <= 1'b0;
      din_q <= 8'h00;
    end else begin
      rdy_q <= rdy_d;
      if (rdy_q && !mem_wr) din_q <= io_sel ? io_rd : ram[ram_a];
    end
  end
  assign mem_din = din_q;
  assign rdy_out = rdy_q;
endmodule
